// File: rtl/paddle_pkg.sv
// Shared paddle/ball definitions: FSM state and direction enums, default field and speed constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package paddle_pkg;

  localparam int PADDLE_W          = 13;
  localparam int FIELD_MAX_DFLT    = 1920;
  localparam int RESET_POS_DFLT    = 960;
  localparam int SPEED_MIN_DFLT    = 4;
  localparam int SPEED_MAX_DFLT    = 16;
  localparam int SPEED_STEP_DFLT   = 2;
  localparam int ACCEL_FRAMES_DFLT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_CRUISE = 2'd2
  } paddle_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } paddle_dir_e;

  // Both buttons pressed cancel each other out.
  function automatic paddle_dir_e decode_dir(input logic up, input logic down);
    if (up && !down) return DIR_UP;
    if (down && !up) return DIR_DOWN;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/paddle_clamp.sv
// Bounded add/subtract on a W-bit position, clipped to [lo, hi] with clip flags; shared with the ball mover.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: base/delta/sub select base -/+ delta; lo/hi are W+1-bit bounds; res is the clipped
//        result, hit_lo/hit_hi flag which bound clipped it. Degenerate range (hi < lo) yields lo, no flags.
module paddle_clamp #(
  parameter int W = 13
) (
  input  logic [W-1:0] base,
  input  logic [W-1:0] delta,
  input  logic         sub,
  input  logic [W:0]   lo,
  input  logic [W:0]   hi,
  output logic [W-1:0] res,
  output logic         hit_lo,
  output logic         hit_hi
);

  logic [W:0] base_x;
  logic [W:0] delta_x;
  logic [W:0] cand;
  logic [W:0] res_x;
  logic       borrow;
  logic       unused_res_msb;

  assign base_x  = {1'b0, base};
  assign delta_x = {1'b0, delta};

  always_comb begin
    // A subtraction that would go negative is caught by the borrow, not by the wrapped value.
    borrow = sub && (delta_x > base_x);
    cand   = sub ? (base_x - delta_x) : (base_x + delta_x);
    res_x  = cand;
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    if (hi < lo) begin
      res_x = lo;
    end else if (borrow || (cand < lo)) begin
      res_x  = lo;
      hit_lo = 1'b1;
    end else if (cand > hi) begin
      res_x  = hi;
      hit_hi = 1'b1;
    end
  end

  // Bounds never exceed W bits, so the top bit of the result is always zero.
  assign res            = res_x[W-1:0];
  assign unused_res_msb = res_x[W];

endmodule

// File: rtl/paddle_axis_ctrl.sv
// Single-axis paddle controller: per-frame position update with speed ramp, edge clamp and edge-contact flags.
// Latency: 1 cycle from the frame_tick edge to pos_out/speed_out/hit_*; at_min/at_max combinational.
// Backpressure: none; frame_tick is the only update strobe, load overrides a coincident tick.
// Ports: clk, rst_n; frame_tick, move_up, move_down, load, size, init_pos in;
//        pos_out, speed_out, moving, at_min, at_max, hit_min, hit_max out.
// Build option: define PADDLE_ACCEL_EN to enable the SPEED_MIN..SPEED_MAX ramp; otherwise motion is always SPEED_MAX.
module paddle_axis_ctrl
  import paddle_pkg::*;
#(
  parameter int W            = PADDLE_W,
  parameter int FIELD_MAX    = FIELD_MAX_DFLT,
  parameter int RESET_POS    = RESET_POS_DFLT,
  parameter int SPEED_MIN    = SPEED_MIN_DFLT,
  parameter int SPEED_MAX    = SPEED_MAX_DFLT,
  parameter int SPEED_STEP   = SPEED_STEP_DFLT,
  parameter int ACCEL_FRAMES = ACCEL_FRAMES_DFLT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_tick,
  input  logic         move_up,
  input  logic         move_down,
  input  logic         load,
  input  logic [W-1:0] size,
  input  logic [W-1:0] init_pos,
  output logic [W-1:0] pos_out,
  output logic [W-1:0] speed_out,
  output logic         moving,
  output logic         at_min,
  output logic         at_max,
  output logic         hit_min,
  output logic         hit_max
);

  localparam logic [W-1:0] SPD_MAX = W'(SPEED_MAX);

  paddle_state_e state_q, state_d;
  paddle_dir_e   dir_q, dir_d, dir_in;
  logic [W-1:0]  speed_q, speed_d;
  logic [W-1:0]  pos_q, pos_d;
  logic          hit_min_q, hit_min_d;
  logic          hit_max_q, hit_max_d;

  logic [W:0]    lo, hi, field_x;
  logic [W-1:0]  clamp_base, clamp_delta, clamp_res;
  logic          clamp_sub, clamp_hit_lo, clamp_hit_hi;

`ifdef PADDLE_ACCEL_EN
  localparam int           CNT_W    = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES + 1) : 1;
  localparam logic [W-1:0] SPD_MIN  = W'(SPEED_MIN);
  localparam logic [W:0]   SPD_STEP = (W+1)'(SPEED_STEP);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       speed_inc;

  assign speed_inc = {1'b0, speed_q} + SPD_STEP;
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = ^{SPEED_MIN, SPEED_STEP, ACCEL_FRAMES};
`endif

  // Legal centre range; upper bound saturates at 0 for oversized paddles.
  assign lo      = {1'b0, size};
  assign field_x = (W+1)'(FIELD_MAX);
  assign hi      = (field_x > lo) ? (field_x - lo) : '0;

  assign dir_in = decode_dir(move_up, move_down);

  always_comb begin : fsm_comb
    state_d = state_q;
    dir_d   = dir_q;
    speed_d = speed_q;
`ifdef PADDLE_ACCEL_EN
    cnt_d   = cnt_q;
`endif
    if (load) begin
      state_d = ST_IDLE;
      dir_d   = DIR_NONE;
      speed_d = '0;
`ifdef PADDLE_ACCEL_EN
      cnt_d   = '0;
`endif
    end else if (frame_tick) begin
      if (dir_in == DIR_NONE) begin
        state_d = ST_IDLE;
        dir_d   = DIR_NONE;
        speed_d = '0;
`ifdef PADDLE_ACCEL_EN
        cnt_d   = '0;
`endif
      end else if ((state_q == ST_IDLE) || (dir_in != dir_q)) begin
        // Start of motion or a reversal: restart from the entry speed in the new direction.
        dir_d = dir_in;
`ifdef PADDLE_ACCEL_EN
        state_d = ST_RAMP;
        speed_d = SPD_MIN;
        cnt_d   = '0;
`else
        state_d = ST_CRUISE;
        speed_d = SPD_MAX;
`endif
      end
`ifdef PADDLE_ACCEL_EN
      else if (state_q == ST_RAMP) begin
        if ((int'(cnt_q) + 1) >= ACCEL_FRAMES) begin
          cnt_d = '0;
          if (speed_inc >= {1'b0, SPD_MAX}) begin
            speed_d = SPD_MAX;
            state_d = ST_CRUISE;
          end else begin
            speed_d = speed_inc[W-1:0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      else begin
        speed_d = SPD_MAX;
      end
    end
  end

  // A load reuses the clamp with zero delta to bring init_pos into range.
  assign clamp_base  = load ? init_pos : pos_q;
  assign clamp_delta = load ? '0 : speed_d;
  assign clamp_sub   = (dir_d == DIR_UP);

  paddle_clamp #(.W(W)) u_clamp (
    .base   (clamp_base),
    .delta  (clamp_delta),
    .sub    (clamp_sub),
    .lo     (lo),
    .hi     (hi),
    .res    (clamp_res),
    .hit_lo (clamp_hit_lo),
    .hit_hi (clamp_hit_hi)
  );

  always_comb begin : pos_comb
    pos_d     = pos_q;
    hit_min_d = 1'b0;
    hit_max_d = 1'b0;
    if (load) begin
      pos_d = clamp_res;
    end else if (frame_tick) begin
      pos_d     = clamp_res;
      hit_min_d = clamp_hit_lo;
      hit_max_d = clamp_hit_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_NONE;
      speed_q   <= '0;
      pos_q     <= W'(RESET_POS);
      hit_min_q <= 1'b0;
      hit_max_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      speed_q   <= speed_d;
      pos_q     <= pos_d;
      hit_min_q <= hit_min_d;
      hit_max_q <= hit_max_d;
    end
  end

`ifdef PADDLE_ACCEL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign pos_out   = pos_q;
  assign speed_out = speed_q;
  assign moving    = (state_q != ST_IDLE);
  assign at_min    = ({1'b0, pos_q} == lo);
  assign at_max    = ({1'b0, pos_q} == hi);
  assign hit_min   = hit_min_q;
  assign hit_max   = hit_max_q;

endmodule

// File: tb/tb_paddle_axis_ctrl.sv
// Bench for paddle_axis_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_paddle_axis_ctrl;

  localparam int W     = 13;
  localparam int FIELD = 1920;
  localparam int RPOS  = 960;
  localparam int SMIN  = 4;
  localparam int SMAX  = 16;
  localparam int SSTEP = 2;
  localparam int AF    = 4;
`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b1;
  logic         frame_tick = 1'b0;
  logic         move_up    = 1'b0;
  logic         move_down  = 1'b0;
  logic         load       = 1'b0;
  logic [W-1:0] size       = 13'd100;
  logic [W-1:0] init_pos   = '0;
  logic [W-1:0] pos_out;
  logic [W-1:0] speed_out;
  logic         moving, at_min, at_max, hit_min, hit_max;

  paddle_axis_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .move_up    (move_up),
    .move_down  (move_down),
    .load       (load),
    .size       (size),
    .init_pos   (init_pos),
    .pos_out    (pos_out),
    .speed_out  (speed_out),
    .moving     (moving),
    .at_min     (at_min),
    .at_max     (at_max),
    .hit_min    (hit_min),
    .hit_max    (hit_max)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Speed depends only on how many consecutive ticks the same direction has been held.
  typedef struct packed {
    int   pos;
    int   speed;
    int   run;
    int   last;
    logic hmin;
    logic hmax;
  } mdl_t;

  function automatic int hi_of(input int sz);
    int h;
    h = FIELD - sz;
    return (h < 0) ? 0 : h;
  endfunction

  function automatic int clamp_load(input int p, input int sz);
    if (hi_of(sz) < sz) return sz;
    if (p < sz) return sz;
    if (p > hi_of(sz)) return hi_of(sz);
    return p;
  endfunction

  function automatic int ramp_speed(input int k);
    int s;
    if (!ACCEL) return SMAX;
    s = SMIN + SSTEP * ((k - 1) / AF);
    return (s > SMAX) ? SMAX : s;
  endfunction

  function automatic mdl_t model_step(input mdl_t s, input logic ft, input logic up, input logic dn,
                                      input logic ld, input int ip, input int sz);
    mdl_t n;
    int   d, lo, hi, cand;
    n      = s;
    n.hmin = 1'b0;
    n.hmax = 1'b0;
    if (ld) begin
      n.pos   = clamp_load(ip, sz);
      n.speed = 0;
      n.run   = 0;
      n.last  = 0;
    end else if (ft) begin
      d = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
      if (d == 0) begin
        n.run   = 0;
        n.speed = 0;
        n.last  = 0;
      end else begin
        n.run   = (s.run == 0 || d != s.last) ? 1 : s.run + 1;
        n.last  = d;
        n.speed = ramp_speed(n.run);
      end
      lo   = sz;
      hi   = hi_of(sz);
      cand = (d == 1) ? s.pos - n.speed : s.pos + n.speed;
      if (hi < lo) n.pos = lo;
      else if (cand < lo) begin n.pos = lo; n.hmin = 1'b1; end
      else if (cand > hi) begin n.pos = hi; n.hmax = 1'b1; end
      else n.pos = cand;
    end
    return n;
  endfunction

  mdl_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{pos: RPOS, speed: 0, run: 0, last: 0, hmin: 1'b0, hmax: 1'b0};
    else        m <= model_step(m, frame_tick, move_up, move_down, load, int'(init_pos), int'(size));
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pos_out",   int'(pos_out),   m.pos);
      chk("speed_out", int'(speed_out), m.speed);
      chk("moving",    int'(moving),    int'(m.run > 0));
      chk("at_min",    int'(at_min),    int'(m.pos == int'(size)));
      chk("at_max",    int'(at_max),    int'(m.pos == hi_of(int'(size))));
      chk("hit_min",   int'(hit_min),   int'(m.hmin));
      chk("hit_max",   int'(hit_max),   int'(m.hmax));
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle's inputs just after an edge, then return 1 time unit past the next edge.
  task automatic step(input logic ft, input logic up, input logic dn, input logic ld, input int ip);
    frame_tick = ft;
    move_up    = up;
    move_down  = dn;
    load       = ld;
    init_pos   = W'(ip);
    @(posedge clk);
    #1;
  endtask

  int exp_sp[9];
  int pos_after9, pos_after30, pos_rev, spd_rev, low_load, low_ticks, pos_hold;
  int dsel;

  initial begin
    if (ACCEL) begin
      exp_sp      = '{4, 4, 4, 4, 6, 6, 6, 6, 8};
      pos_after9  = 1008;
      pos_after30 = 1272;
      pos_rev     = 1268;
      spd_rev     = 4;
      low_load    = 326;
      low_ticks   = 25;
    end else begin
      exp_sp      = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
      pos_after9  = 1104;
      pos_after30 = 1440;
      pos_rev     = 1424;
      spd_rev     = 16;
      low_load    = 110;
      low_ticks   = 1;
    end

    // Reset with size 100.
    #1 rst_n = 1'b0;
    #2 cmp_en = 1'b1;
    chk("rst_pos",    int'(pos_out),   960);
    chk("rst_speed",  int'(speed_out), 0);
    chk("rst_moving", int'(moving),    0);
    chk("rst_hits",   int'(hit_min | hit_max), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // No input for 10 ticks: position holds.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    chk("idle_pos", int'(pos_out), 960);

    // Hold down: speed ramp and position accumulation.
    for (int k = 0; k < 30; k++) begin
      step(1, 0, 1, 0, 0);
      if (k < 9) chk("ramp_speed", int'(speed_out), exp_sp[k]);
      if (k == 8) chk("ramp_pos9", int'(pos_out), pos_after9);
      if (k == 24) begin
        chk("cruise_speed",  int'(speed_out), 16);
        chk("cruise_moving", int'(moving), 1);
      end
      step(0, 0, 1, 0, 0);
    end
    chk("ramp_pos30", int'(pos_out), pos_after30);

    // Reversal, then both buttons.
    step(1, 1, 0, 0, 0);
    chk("rev_speed", int'(speed_out), spd_rev);
    chk("rev_pos",   int'(pos_out),   pos_rev);
    step(1, 1, 1, 0, 0);
    chk("both_moving", int'(moving),    0);
    chk("both_speed",  int'(speed_out), 0);
    chk("both_pos",    int'(pos_out),   pos_rev);

    // Load wins over a coincident tick and is clamped.
    step(1, 0, 1, 1, 5);
    chk("load_pos",    int'(pos_out), 100);
    chk("load_moving", int'(moving),  0);

    // Clip at the lower bound at full speed; no wrap.
    step(0, 0, 0, 1, low_load);
    for (int i = 0; i < low_ticks; i++) step(1, 1, 0, 0, 0);
    chk("lo_pos",     int'(pos_out),   100);
    chk("lo_speed",   int'(speed_out), 16);
    chk("lo_hit",     int'(hit_min),   1);
    chk("lo_at_min",  int'(at_min),    1);
    step(0, 1, 0, 0, 0);
    chk("lo_hit_end", int'(hit_min),   0);
    step(1, 1, 0, 0, 0);
    chk("lo_hit_again", int'(hit_min), 1);
    chk("lo_pos_again", int'(pos_out), 100);

    // Clip at the upper bound.
    step(0, 0, 0, 1, 1810);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    chk("hi_pos",    int'(pos_out), 1820);
    chk("hi_hit",    int'(hit_max), 1);
    chk("hi_at_max", int'(at_max),  1);

    // Asynchronous reset in the middle of a ramp.
    step(0, 0, 0, 1, 960);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    pos_hold = int'(pos_out);
    chk("pre_rst_moved", int'(pos_hold != 960), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pos",    int'(pos_out),   960);
    chk("arst_speed",  int'(speed_out), 0);
    chk("arst_moving", int'(moving),    0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Degenerate sizes: position forced to lo, no hit pulses.
    size = 13'd1000;
    step(1, 0, 1, 0, 0);
    chk("deg_pos",  int'(pos_out), 1000);
    chk("deg_hits", int'(hit_min | hit_max), 0);
    step(1, 1, 0, 0, 0);
    chk("deg_pos2", int'(pos_out), 1000);
    size = 13'd2000;
    step(1, 0, 1, 0, 0);
    chk("deg_pos3", int'(pos_out), 2000);
    size = 13'd100;
    step(0, 0, 0, 1, 960);

    // Randomized traffic, checked every cycle by the model comparison.
    dsel = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) dsel = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        if ($urandom_range(0, 9) == 0) size = W'($urandom_range(900, 2100));
        else                           size = W'($urandom_range(0, 300));
      end
      step(logic'($urandom_range(0, 1)), logic'(dsel == 1 || dsel == 3), logic'(dsel >= 2),
           logic'($urandom_range(0, 49) == 0), int'($urandom_range(0, 2100)));
    end

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/paddle_axis_ctrl.md
# paddle_axis_ctrl

Parametrised single-axis paddle controller for the VGA ping-pong game, replacing the fixed-speed, every-clock paddle mover. It updates the paddle centre position once per frame tick, ramps speed from a minimum to a maximum while a direction is held, clamps underflow-safe against both field edges, and reports edge contact. One instance per paddle sits between the input debounce logic and the renderer/collision logic.

## Interface
- W, 13, width of position, size and speed values
- FIELD_MAX, 1920, field extent along the axis in pixels
- RESET_POS, 960, position loaded by reset
- SPEED_MIN, 4, first-tick speed after motion starts or reverses
- SPEED_MAX, 16, ramp ceiling
- SPEED_STEP, 2, ramp increment
- ACCEL_FRAMES, 4, frame ticks per ramp increment (>=1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame; the only update strobe
- move_up  in  1  request motion toward 0
- move_down  in  1  request motion toward FIELD_MAX
- load  in  1  synchronous re-init to init_pos
- size  in  W  paddle half-extent; legal bounds are [size, FIELD_MAX-size]
- init_pos  in  W  value taken by load, clamped to bounds
- pos_out  out  W  paddle centre position
- speed_out  out  W  speed applied on the most recent tick
- moving  out  1  state is not IDLE
- at_min / at_max  out  1  pos_out equals lower / upper bound
- hit_min / hit_max  out  1  one-cycle pulse: last tick's move was clipped at that bound

## Operation
- Direction: up only -> UP; down only -> DOWN; none or both -> NONE.
- FSM states IDLE, RAMP, CRUISE; evaluated only on frame_tick cycles.
- IDLE: dir NONE -> stay, speed 0. Dir UP/DOWN -> RAMP, speed SPEED_MIN, move applied on same tick.
- RAMP: tick counter increments each tick; on reaching ACCEL_FRAMES, counter clears and speed += SPEED_STEP, saturating at SPEED_MAX; on saturation -> CRUISE.
- CRUISE: speed SPEED_MAX.
- RAMP/CRUISE: dir NONE -> IDLE, speed 0, counter 0. Dir reversal -> RAMP, speed SPEED_MIN, counter 0, move in the new direction on that tick.
- Arithmetic in W+1 bits: lo = size; hi = FIELD_MAX - size, saturating at 0. Candidate = pos -/+ speed; a result below lo (including negative) -> lo, hit_min pulse; above hi -> hi, hit_max pulse. Position never wraps.
- Degenerate size (hi < lo): pos forced to lo each tick; no hit pulses.
- Moving against an already-reached bound still pulses the hit output every tick; FSM and speed continue normally.
- load: pos <- clamp(init_pos), FSM -> IDLE, speed 0, counter 0; load has priority over a coincident frame_tick.
- size change mid-game takes effect at the next tick or load; no retroactive clamp.

## Timing
- Reset (async assert, sync-safe deassert): pos_out = RESET_POS, speed_out 0, state IDLE, moving 0, hit_min/hit_max 0; at_min/at_max derived from current size.
- Inputs sampled on the clk edge where frame_tick = 1; pos_out/speed_out/hit_* valid the following cycle (latency 1).
- hit_* high for exactly one cycle, then 0 until the next clipping tick.
- at_min/at_max combinational from the pos_out register and size.
- Non-tick cycles: all registers hold.

## Configuration
- PADDLE_ACCEL_EN defined: ramp as described.
- Undefined: no counter or ramp logic; any held direction moves at SPEED_MAX from the first tick; RAMP is never entered (IDLE <-> CRUISE only); reversal is immediate at SPEED_MAX.

## Structure
- paddle_pkg: state enum (IDLE, RAMP, CRUISE), direction enum, default FIELD_MAX/speed constants shared with ball and collision logic.
- Sub-module paddle_clamp: combinational W+1-bit bounded add/subtract returning the clipped value plus hit_lo/hit_hi; reused by the ball mover.

## Test plan
- Reset with size=100: pos_out=960, speed_out=0, moving=0; release, 10 ticks with no input -> pos stays 960.
- Hold move_down, defaults, PADDLE_ACCEL_EN: speeds 4,4,4,4,6,6,6,6,8 ...; reach 16 and CRUISE after 24 ticks; pos increments match each speed.
- size=100, pos=110, move_up tick at speed 16 -> pos 100, hit_min one cycle, at_min=1; no wrap to ~8190.
- Cruising down, switch to move_up -> next tick speed 4, moves toward 0, state RAMP; both buttons -> IDLE, pos holds.
- load with init_pos=5, size=100 coincident with frame_tick -> pos 100, IDLE; rst_n asserted mid-ramp -> immediate pos 960, speed 0.
- PADDLE_ACCEL_EN undefined: first held tick moves by 16; size=1000 -> pos forced to 1000, no hit pulses.
